// File: rtl/mmio_slot_fabric.sv
// rtl/mmio_slot_fabric.sv - MMIO slot decoder with ack handshake, error capture; timeout optional via MMIO_TIMEOUT_EN
module mmio_slot_fabric #(
    parameter int N_SLOT  = 64,
    parameter int REG_AW  = 5,
    parameter int ADDR_W  = 21,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mmio_cs,
    input  logic                  mmio_wr,
    input  logic                  mmio_rd,
    input  logic [ADDR_W-1:0]     mmio_addr,
    input  logic [31:0]           mmio_wr_data,
    output logic [31:0]           mmio_rd_data,
    output logic                  mmio_ready,
    output logic                  mmio_err,
    output logic                  mmio_busy,
    output logic [N_SLOT-1:0]     slot_cs,
    output logic [N_SLOT-1:0]     slot_rd,
    output logic [N_SLOT-1:0]     slot_wr,
    output logic [REG_AW-1:0]     slot_reg_addr,
    output logic [31:0]           slot_wr_data,
    input  logic [32*N_SLOT-1:0]  slot_rd_data,
    input  logic [N_SLOT-1:0]     slot_ack,
    output logic [ADDR_W-1:0]     err_addr,
    output logic [7:0]            err_cnt
);
    localparam int SLOT_W = $clog2(N_SLOT);
    localparam logic [SLOT_W:0]   SLOT_LIM = (SLOT_W+1)'(N_SLOT);
    localparam logic [N_SLOT-1:0] ONE_HOT0 = N_SLOT'(1);
    localparam logic [31:0]       ERR_DATA = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [SLOT_W-1:0] sel_q;
    logic              is_rd_q;
    logic              first_q;
    logic              err_q;

    logic [SLOT_W-1:0] req_slot;
    logic              req_legal;
    logic              req_ok;
    logic              ack_sel;
    logic [31:0]       sel_data;
    logic [N_SLOT-1:0] sel_oh;
    logic [7:0]        err_cnt_inc;
    logic              tmo;

    assign req_slot    = mmio_addr[REG_AW +: SLOT_W];
    assign req_legal   = mmio_rd ^ mmio_wr;
    assign req_ok      = req_legal && ({1'b0, req_slot} < SLOT_LIM);
    assign ack_sel     = slot_ack[sel_q];
    assign sel_data    = slot_rd_data[32*sel_q +: 32];
    assign sel_oh      = ONE_HOT0 << sel_q;
    assign err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    assign slot_reg_addr = addr_q[REG_AW-1:0];
    assign slot_wr_data  = wdata_q;

`ifdef MMIO_TIMEOUT_EN
    localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tcnt;

    // Counts ACCESS cycles already spent; abort in the cycle that would reach TIMEOUT.
    always_ff @(posedge clk) begin
        if (!reset)
            tcnt <= '0;
        else if (state == ACCESS)
            tcnt <= tcnt + 16'd1;
        else
            tcnt <= '0;
    end

    assign tmo = (tcnt == T_LAST);
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        slot_cs      = '0;
        slot_rd      = '0;
        slot_wr      = '0;
        mmio_ready   = 1'b0;
        mmio_err     = 1'b0;
        mmio_busy    = 1'b0;
        mmio_rd_data = '0;
        case (state)
            IDLE: begin
                if (mmio_cs)
                    state_nx = req_ok ? ACCESS : DONE;
            end
            ACCESS: begin
                mmio_busy = 1'b1;
                slot_cs   = sel_oh;
                if (first_q) begin
                    slot_rd = is_rd_q ? sel_oh : '0;
                    slot_wr = is_rd_q ? '0 : sel_oh;
                end
                // ack has priority over a coincident timeout
                if (ack_sel || tmo)
                    state_nx = DONE;
            end
            DONE: begin
                mmio_busy    = 1'b1;
                mmio_ready   = 1'b1;
                mmio_err     = err_q;
                mmio_rd_data = rdata_q;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            sel_q    <= '0;
            is_rd_q  <= 1'b0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mmio_cs) begin
                        addr_q  <= mmio_addr;
                        wdata_q <= mmio_wr_data;
                        sel_q   <= req_slot;
                        is_rd_q <= mmio_rd;
                        first_q <= 1'b1;
                        err_q   <= !req_ok;
                        if (!req_ok) begin
                            rdata_q  <= ERR_DATA;
                            err_addr <= mmio_addr;
                            err_cnt  <= err_cnt_inc;
                        end
                    end
                end
                ACCESS: begin
                    first_q <= 1'b0;
                    if (ack_sel) begin
                        err_q   <= 1'b0;
                        rdata_q <= is_rd_q ? sel_data : '0;
                    end else if (tmo) begin
                        err_q    <= 1'b1;
                        rdata_q  <= ERR_DATA;
                        err_addr <= addr_q;
                        err_cnt  <= err_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_slot_fabric.sv
// tb/tb_mmio_slot_fabric.sv - directed and random bench for mmio_slot_fabric with slot memory reference
module tb_mmio_slot_fabric;
    localparam int N   = 24;
    localparam int RAW = 5;
    localparam int AW  = 21;
    localparam int TMO = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_DEAD;

    logic            clk = 1'b0;
    logic            reset;
    logic            mmio_cs, mmio_wr, mmio_rd;
    logic [AW-1:0]   mmio_addr;
    logic [31:0]     mmio_wr_data;
    logic [31:0]     mmio_rd_data;
    logic            mmio_ready, mmio_err, mmio_busy;
    logic [N-1:0]    slot_cs, slot_rd, slot_wr;
    logic [RAW-1:0]  slot_reg_addr;
    logic [31:0]     slot_wr_data;
    logic [32*N-1:0] slot_rd_data;
    logic [N-1:0]    slot_ack;
    logic [AW-1:0]   err_addr;
    logic [7:0]      err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] smem    [0:N*32-1];
    logic [31:0] ref_mem [0:N*32-1];
    int          exp_cnt;
    logic [AW-1:0] exp_eaddr;

    mmio_slot_fabric #(.N_SLOT(N), .REG_AW(RAW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_data(mmio_rd_data), .mmio_ready(mmio_ready),
        .mmio_err(mmio_err), .mmio_busy(mmio_busy),
        .slot_cs(slot_cs), .slot_rd(slot_rd), .slot_wr(slot_wr),
        .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
        .slot_rd_data(slot_rd_data), .slot_ack(slot_ack),
        .err_addr(err_addr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Slot cores: each presents its register selected by the shared register address.
    always_comb begin
        slot_rd_data = '0;
        for (int i = 0; i < N; i++)
            slot_rd_data[32*i +: 32] = smem[i*32 + int'(slot_reg_addr)];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] mk_addr(input int s, input int r);
        logic [AW-1:0] a;
        a = AW'($urandom);
        a[RAW +: 5] = s[4:0];
        a[RAW-1:0]  = r[4:0];
        return a;
    endfunction

    // k = ACCESS cycle in which the selected slot acks (0 = never)
    task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                             input logic [31:0] wdata, input int k);
        int slot, reg_i, exp_acc, exp_lat, n, lat, cs_cyc, busy_cyc, rd_str, wr_str, stray, bad_hold;
        bit legal, valid, exp_err, got;
        logic [31:0] exp_data;
        logic [N-1:0] oh, noise;

        slot  = int'(addr[RAW +: 5]);
        reg_i = int'(addr[RAW-1:0]);
        legal = rd ^ wr;
        valid = legal && (slot < N);
        oh    = '0;
        if (valid) oh[slot] = 1'b1;

        if (!valid) begin
            exp_acc = 0;
            exp_err = 1'b1;
        end else begin
`ifdef MMIO_TIMEOUT_EN
            if (k == 0 || k > TMO) begin
                exp_acc = TMO;
                exp_err = 1'b1;
            end else begin
                exp_acc = k;
                exp_err = 1'b0;
            end
`else
            exp_acc = k;
            exp_err = 1'b0;
`endif
        end
        exp_lat  = exp_acc + 1;
        exp_data = exp_err ? ERR_DATA : (rd ? ref_mem[slot*32 + reg_i] : 32'h0);
        if (valid && wr) ref_mem[slot*32 + reg_i] = wdata;
        if (exp_err) begin
            exp_cnt   = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            exp_eaddr = addr;
        end

        @(negedge clk);
        check("idle_busy", 32'(mmio_busy), 32'h0);
        mmio_cs = 1'b1; mmio_rd = rd; mmio_wr = wr;
        mmio_addr = addr; mmio_wr_data = wdata;

        n = 0; lat = -1; got = 1'b0;
        cs_cyc = 0; busy_cyc = 0; rd_str = 0; wr_str = 0; stray = 0; bad_hold = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
                mmio_wr_data = 32'($urandom);
            end
            busy_cyc += int'(mmio_busy);
            for (int i = 0; i < N; i++) begin
                if (slot_rd[i]) begin
                    if (valid && i == slot) rd_str++; else stray++;
                end
                if (slot_wr[i]) begin
                    if (valid && i == slot) wr_str++; else stray++;
                    smem[i*32 + int'(slot_reg_addr)] = slot_wr_data;
                end
            end
            if (slot_cs != '0) begin
                if (slot_cs == oh) cs_cyc++; else stray++;
                if (int'(slot_reg_addr) != reg_i || (wr && slot_wr_data !== wdata)) bad_hold++;
            end
            if (mmio_ready) begin
                got = 1'b1;
                lat = n;
                check("err_flag", 32'(mmio_err), 32'(exp_err));
                check("rd_data", mmio_rd_data, exp_data);
                slot_ack = '0;
            end else begin
                noise = N'($urandom);
                if (valid) noise[slot] = (slot_cs[slot] && cs_cyc == k);
                slot_ack = noise;
            end
        end
        slot_ack = '0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("rd_strobes", 32'(rd_str), 32'(valid && rd));
        check("wr_strobes", 32'(wr_str), 32'(valid && wr));
        check("stray_slot", 32'(stray), 32'h0);
        check("cs_cycles", 32'(cs_cyc), 32'(exp_acc));
        check("busy_cycles", 32'(busy_cyc), 32'(exp_lat));
        check("hold_stable", 32'(bad_hold), 32'h0);
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
        check("err_addr", 32'(err_addr), 32'(exp_eaddr));
    endtask

    initial begin
        int seen, op, a_slot;
        logic [AW-1:0] a;

        for (int i = 0; i < N*32; i++) begin
            smem[i]    = $urandom;
            ref_mem[i] = smem[i];
        end
        exp_cnt = 0; exp_eaddr = '0;
        reset = 1'b0; mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
        mmio_addr = '0; mmio_wr_data = '0; slot_ack = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst_ready", 32'(mmio_ready), 32'h0);
        check("rst_busy", 32'(mmio_busy), 32'h0);
        check("rst_slot_cs", 32'(slot_cs), 32'h0);
        check("rst_rd_data", mmio_rd_data, 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
        check("rst_err_addr", 32'(err_addr), 32'h0);

        a = mk_addr(3, 7);
        smem[3*32 + 7] = 32'h1234_5678; ref_mem[3*32 + 7] = 32'h1234_5678;
        do_access(1'b1, 1'b0, a, 32'h0, 1);
        do_access(1'b0, 1'b1, mk_addr(9, 4), 32'hCAFE_F00D, 5);
        do_access(1'b1, 1'b0, mk_addr(9, 4), 32'h0, 2);
`ifdef MMIO_TIMEOUT_EN
        do_access(1'b1, 1'b0, mk_addr(20, 1), 32'h0, 0);
`else
        do_access(1'b1, 1'b0, mk_addr(20, 1), 32'h0, 20);
`endif
        do_access(1'b1, 1'b0, mk_addr(20, 2), 32'h0, TMO);
        do_access(1'b1, 1'b0, mk_addr(27, 3), 32'h0, 1);
        do_access(1'b1, 1'b1, mk_addr(4, 3), 32'h1, 1);
        do_access(1'b0, 1'b0, mk_addr(4, 3), 32'h2, 1);
        do_access(1'b0, 1'b1, mk_addr(N-1, 31), 32'h5555_AAAA, 1);
        do_access(1'b1, 1'b0, mk_addr(N-1, 31), 32'h0, 1);

        for (int t = 0; t < 80; t++) begin
            op     = $urandom_range(0, 9);
            a_slot = $urandom_range(0, 31);
            a      = mk_addr(a_slot, $urandom_range(0, 31));
            do_access(op == 0 || op >= 6, op == 0 || (op >= 2 && op <= 5), a,
                      $urandom, $urandom_range(1, 11));
        end

        for (int t = 0; t < 300; t++)
            do_access(1'b0, 1'b0, mk_addr($urandom_range(0, 31), 0), 32'h0, 1);
        check("err_cnt_sat", 32'(err_cnt), 32'd255);

        @(negedge clk);
        mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_addr = mk_addr(5, 2);
        @(negedge clk);
        mmio_cs = 1'b0; mmio_rd = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(mmio_busy), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_mid_cs", 32'(slot_cs), 32'h0);
        check("rst_mid_strobe", 32'(slot_rd | slot_wr), 32'h0);
        check("rst_mid_busy", 32'(mmio_busy), 32'h0);
        check("rst_mid_err_cnt", 32'(err_cnt), 32'h0);
        check("rst_mid_err_addr", 32'(err_addr), 32'h0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen += int'(mmio_ready);
        end
        check("rst_no_ready", 32'(seen), 32'h0);
        exp_cnt = 0; exp_eaddr = '0;
        do_access(1'b1, 1'b0, mk_addr(0, 9), 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
